ov7670_config_sequencer: RTL and testbench
==========================================

// Module: ov7670_config_sequencer
// PURPOSE
//  Walks the OV7670 configuration ROM from address 0 and turns each 16-bit entry
//  {reg[15:8], val[7:0]} into one SCCB register-write request to the SCCB master.
//  Entry 16'hFFF0 inserts a fixed settle delay and entry 16'hFFFF ends the sequence.
//  Sits between the config ROM and the SCCB master. Starts on a start pulse and
//  reports done/error to the top-level camera bring-up logic.
// PARAMETERS
//  DELAY_CYCLES  1_000_000  clk cycles waited for a 16'hFFF0 entry (10 ms @ 100 MHz)
//  MAX_RETRY     3          extra attempts for a NACKed write before aborting
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   synchronous active-low reset
//  start        in   1   1-cycle pulse; begins the sequence from ROM address 0
//  rom_addr     out  8   ROM address
//  rom_clk_en   out  1   ROM read enable; ROM dout is valid the cycle after it is high
//  rom_dout     in   16  ROM entry
//  sccb_valid   out  1   write request valid
//  sccb_ready   in   1   SCCB master accepts the request (valid&&ready = accept)
//  sccb_reg     out  8   register address; stable while sccb_valid is high
//  sccb_data    out  8   register value; stable while sccb_valid is high
//  sccb_done    in   1   1-cycle pulse when the accepted write finishes
//  sccb_nack    in   1   sampled with sccb_done; 1 = the slave did not ACK
//  busy         out  1   sequence in progress
//  done         out  1   sticky; sequence ended (FFFF entry or address wrap)
//  error        out  1   sticky; aborted after MAX_RETRY+1 NACKs on one entry
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - Outputs: rom_addr=0, rom_clk_en=0, sccb_valid=0, sccb_reg=0, sccb_data=0,
//     busy=0, done=0, error=0.
//   - State goes to IDLE, and the delay counter and retry counter clear.
//   - A reset mid-sequence drops sccb_valid in the next cycle. It does not wait
//     for an outstanding sccb_done.
//  States:
//   - IDLE: wait for start. On start, clear done/error, set rom_addr=0, set busy=1,
//     go to FETCH.
//   - FETCH: rom_clk_en=1 for exactly one cycle, then go to LATCH.
//   - LATCH: register rom_dout, then go to DECODE.
//   - DECODE:
//     - FFFF: go to FINISH.
//     - FFF0: load the counter with DELAY_CYCLES-1, go to DELAY.
//     - Any other entry: set sccb_reg/sccb_data, clear the retry count, go to SEND.
//   - DELAY: decrement each cycle. At 0 go to NEXT.
//     - Exactly DELAY_CYCLES cycles are spent in DELAY.
//   - SEND: sccb_valid=1 until a cycle with sccb_ready=1. In that cycle it is
//     accepted; sccb_valid=0 from the next cycle, then go to WAIT_DONE.
//   - WAIT_DONE: wait for sccb_done.
//     - nack=0: go to NEXT.
//     - nack=1 and retry<MAX_RETRY: increment retry, go back to SEND.
//     - nack=1 and retry=MAX_RETRY: error=1, go to FINISH.
//   - NEXT:
//     - rom_addr==255: go to FINISH (the address does not wrap).
//     - Otherwise rom_addr+1, go to FETCH.
//   - FINISH: busy=0; done=1 if error=0 (done and error are never both 1). Go to IDLE.
//  Timing rules:
//   - Non-delay entry with ready already high: 4 cycles from FETCH to accept.
//   - start while busy=1 is ignored.
//   - start in IDLE after done/error restarts from address 0.
//   - sccb_done outside WAIT_DONE is ignored.
//   - sccb_ready outside SEND has no effect.
//   - rom_addr changes only in IDLE (on start) and in NEXT.
// TESTING
//  1. ROM {1280, FFF0, 1201, FFFF}, ready=1, done 3 cycles after accept ->
//     writes (12,80) then (12,01); gap >= DELAY_CYCLES between them; done=1, busy=0.
//  2. ready held low 20 cycles during SEND -> sccb_valid high and reg/data
//     unchanged all 20 cycles; exactly one accept.
//  3. NACK on entry 0 twice, then ACK -> 3 accepts of the same reg/data; done=1, error=0.
//  4. NACK on all 4 attempts (MAX_RETRY=3) -> error=1, done=0, busy=0; no further
//     ROM reads.
//  5. ROM with no FFFF (256 plain entries) -> 256 writes; rom_addr stops at 255; done=1.
//  6. rst_n=0 during DELAY or SEND, then start -> all outputs at reset values;
//     restart fetches address 0.

Source files
------------

// File: rtl/ov7670_config_sequencer_if.sv
// ROM read port and SCCB register-write request channel. The config sequencer
// drives this bundle as master. The ROM and the SCCB master sit on the slave side.
interface ov7670_config_sequencer_if;
    logic [7:0]  rom_addr;
    logic        rom_clk_en;
    logic [15:0] rom_dout;
    logic        sccb_valid;
    logic        sccb_ready;
    logic [7:0]  sccb_reg;
    logic [7:0]  sccb_data;
    logic        sccb_done;
    logic        sccb_nack;

    modport master (
        output rom_addr, rom_clk_en, sccb_valid, sccb_reg, sccb_data,
        input  rom_dout, sccb_ready, sccb_done, sccb_nack
    );

    modport slave (
        input  rom_addr, rom_clk_en, sccb_valid, sccb_reg, sccb_data,
        output rom_dout, sccb_ready, sccb_done, sccb_nack
    );
endinterface

// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 configuration ROM and issues one SCCB register write per entry.
// 16'hFFF0 inserts a settle delay, 16'hFFFF ends the sequence, and NACKed writes are retried.
module ov7670_config_sequencer #(
    parameter int unsigned DELAY_CYCLES = 1_000_000,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    ov7670_config_sequencer_if.master        bus,
    output logic                             busy,
    output logic                             done,
    output logic                             error
);
    localparam logic [15:0]   ENTRY_END   = 16'hFFFF;
    localparam logic [15:0]   ENTRY_DELAY = 16'hFFF0;
    localparam int unsigned   DW          = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam int unsigned   RW          = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [DW-1:0] DELAY_LOAD  = DW'(DELAY_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRY);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_DECODE,
        S_DELAY,
        S_SEND,
        S_WAIT_DONE,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [15:0]   entry;
    logic [DW-1:0] delay_cnt;
    logic [RW-1:0] retry_cnt;

    // Single-cycle datapath strobes decoded from the current state and inputs.
    logic do_start;
    logic do_latch;
    logic do_load_delay;
    logic do_count;
    logic do_load_req;
    logic do_retry;
    logic do_abort;
    logic do_advance;
    logic do_finish;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal driven here gets a default first; a path that skipped one would infer a latch.
    always_comb begin
        next_state     = state;
        bus.rom_clk_en = 1'b0;
        bus.sccb_valid = 1'b0;
        do_start       = 1'b0;
        do_latch       = 1'b0;
        do_load_delay  = 1'b0;
        do_count       = 1'b0;
        do_load_req    = 1'b0;
        do_retry       = 1'b0;
        do_abort       = 1'b0;
        do_advance     = 1'b0;
        do_finish      = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    do_start   = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                bus.rom_clk_en = 1'b1;
                next_state     = S_LATCH;
            end
            S_LATCH: begin
                do_latch   = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                if (entry == ENTRY_END) begin
                    next_state = S_FINISH;
                end else if (entry == ENTRY_DELAY) begin
                    do_load_delay = 1'b1;
                    next_state    = S_DELAY;
                end else begin
                    do_load_req = 1'b1;
                    next_state  = S_SEND;
                end
            end
            S_DELAY: begin
                // Loaded with DELAY_CYCLES-1, so counting down to zero spends DELAY_CYCLES cycles here.
                if (delay_cnt == '0) begin
                    next_state = S_NEXT;
                end else begin
                    do_count = 1'b1;
                end
            end
            S_SEND: begin
                bus.sccb_valid = 1'b1;
                if (bus.sccb_ready) begin
                    next_state = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (bus.sccb_done) begin
                    if (!bus.sccb_nack) begin
                        next_state = S_NEXT;
                    end else if (retry_cnt < RETRY_LAST) begin
                        do_retry   = 1'b1;
                        next_state = S_SEND;
                    end else begin
                        do_abort   = 1'b1;
                        next_state = S_FINISH;
                    end
                end
            end
            S_NEXT: begin
                // The last ROM address ends the sequence instead of wrapping back to 0.
                if (bus.rom_addr == 8'hFF) begin
                    next_state = S_FINISH;
                end else begin
                    do_advance = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_FINISH: begin
                do_finish  = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.rom_addr  <= '0;
            bus.sccb_reg  <= '0;
            bus.sccb_data <= '0;
            entry         <= '0;
            delay_cnt     <= '0;
            retry_cnt     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            if (do_start) begin
                bus.rom_addr <= '0;
                busy         <= 1'b1;
                done         <= 1'b0;
                error        <= 1'b0;
            end

            if (do_latch) begin
                entry <= bus.rom_dout;
            end

            if (do_load_delay) begin
                delay_cnt <= DELAY_LOAD;
            end else if (do_count) begin
                delay_cnt <= delay_cnt - 1'b1;
            end

            // Request fields hold across retries so every attempt resends the same write.
            if (do_load_req) begin
                bus.sccb_reg  <= entry[15:8];
                bus.sccb_data <= entry[7:0];
                retry_cnt     <= '0;
            end else if (do_retry) begin
                retry_cnt <= retry_cnt + 1'b1;
            end

            if (do_abort) begin
                error <= 1'b1;
            end

            if (do_advance) begin
                bus.rom_addr <= bus.rom_addr + 1'b1;
            end

            if (do_finish) begin
                busy <= 1'b0;
                done <= ~error;
            end
        end
    end
endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Randomized bench for ov7670_config_sequencer: a ROM and SCCB-master model drive the DUT,
// and a sequence-level reference model predicts writes, ROM reads and the final status.
module tb_ov7670_config_sequencer;
    localparam int DELAY = 16;
    localparam int RETRY = 3;

    typedef enum int { RDY_ALWAYS, RDY_RANDOM, RDY_HOLD } rdy_mode_t;

    typedef struct {
        logic [7:0] r;
        logic [7:0] d;
        int         dly;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy;
    logic done;
    logic error;

    ov7670_config_sequencer_if bus();

    ov7670_config_sequencer #(
        .DELAY_CYCLES (DELAY),
        .MAX_RETRY    (RETRY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .error (error)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic [15:0] rom [256];
    bit          nack_plan [1024];

    wr_t exp_q[$];
    bit  exp_done;
    bit  exp_error;
    int  exp_reads;
    int  exp_last_addr;

    rdy_mode_t   ready_mode;
    int          hold_left;
    int          done_lat_min;
    int          done_lat_max;
    bit          spurious_en;
    bit          inject_start;
    int          ncyc = 0;
    int          reads;
    int          acc_cnt;
    int          wait_cycles;
    int          last_fetch;
    int          last_acc;
    int          first_addr;
    int          done_timer;
    bit          fetched;
    bit          was_waiting;
    bit          was_accepted;
    bit          pend_nack;
    bit          rom_pend;
    logic [7:0]  rom_rd_addr;
    logic [15:0] held;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: walk the ROM entry by entry and list the writes the SCCB master should see.
    task automatic model_run();
        int k   = 0;
        int dly = 0;
        wr_t w;
        exp_q.delete();
        exp_done  = 1'b0;
        exp_error = 1'b0;
        exp_reads = 0;
        for (int a = 0; a < 256; a++) begin
            exp_reads++;
            exp_last_addr = a;
            if (rom[a] == 16'hFFFF) begin
                exp_done = 1'b1;
                return;
            end
            if (rom[a] == 16'hFFF0) begin
                dly++;
                continue;
            end
            for (int t = 0; t <= RETRY; t++) begin
                bit nacked;
                w.r   = rom[a][15:8];
                w.d   = rom[a][7:0];
                w.dly = dly;
                exp_q.push_back(w);
                dly    = 0;
                nacked = nack_plan[k];
                k++;
                if (!nacked) break;
                if (t == RETRY) begin
                    exp_error = 1'b1;
                    return;
                end
            end
        end
        exp_done = 1'b1;
    endtask

    task automatic accept();
        int idx = acc_cnt;
        acc_cnt++;
        was_accepted = 1'b1;
        if (idx < exp_q.size()) begin
            check("wr_reg", bus.sccb_reg, exp_q[idx].r);
            check("wr_data", bus.sccb_data, exp_q[idx].d);
            if (exp_q[idx].dly > 0)
                check("delay_gap", 32'((ncyc - last_acc) >= exp_q[idx].dly * DELAY), 1);
        end else begin
            check("extra_write", idx, exp_q.size());
        end
        if (fetched && ready_mode == RDY_ALWAYS)
            check("fetch_to_accept", ncyc - last_fetch, 3);
        fetched    = 1'b0;
        last_acc   = ncyc;
        done_timer = int'($urandom_range(done_lat_max, done_lat_min));
        pend_nack  = (idx < 1024) ? nack_plan[idx] : 1'b0;
    endtask

    // ROM and SCCB-master model: inputs change on the falling edge, away from the DUT's sampling edge.
    always @(negedge clk) begin
        ncyc++;
        bus.rom_dout  = rom_pend ? rom[rom_rd_addr] : 16'($urandom);
        rom_pend      = 1'b0;
        bus.sccb_done = 1'b0;
        bus.sccb_nack = 1'b0;
        if (!rst_n) begin
            bus.sccb_ready = 1'b0;
            done_timer     = 0;
            was_waiting    = 1'b0;
            was_accepted   = 1'b0;
        end else begin
            if (bus.rom_clk_en) begin
                if (reads == 0) first_addr = int'(bus.rom_addr);
                reads++;
                last_fetch  = ncyc;
                fetched     = 1'b1;
                rom_pend    = 1'b1;
                rom_rd_addr = bus.rom_addr;
            end
            if (was_waiting) begin
                check("valid_hold", bus.sccb_valid, 1);
                check("req_hold", {bus.sccb_reg, bus.sccb_data}, held);
            end
            if (was_accepted) check("valid_drop", bus.sccb_valid, 0);
            was_waiting  = 1'b0;
            was_accepted = 1'b0;

            if (done_timer > 0) begin
                done_timer--;
                if (done_timer == 0) begin
                    bus.sccb_done = 1'b1;
                    bus.sccb_nack = pend_nack;
                end
            end else if (spurious_en && $urandom_range(0, 15) == 0) begin
                bus.sccb_done = 1'b1;
                bus.sccb_nack = 1'($urandom_range(0, 1));
            end

            case (ready_mode)
                RDY_ALWAYS: bus.sccb_ready = 1'b1;
                RDY_RANDOM: bus.sccb_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (bus.sccb_valid && hold_left > 0) begin
                        bus.sccb_ready = 1'b0;
                        hold_left--;
                    end else begin
                        bus.sccb_ready = 1'b1;
                    end
                end
            endcase

            if (bus.sccb_valid && bus.sccb_ready) begin
                accept();
            end else if (bus.sccb_valid) begin
                was_waiting = 1'b1;
                wait_cycles++;
                held        = {bus.sccb_reg, bus.sccb_data};
            end
        end
    end

    task automatic check_reset(input string name);
        check({name, "_rom_addr"}, bus.rom_addr, 0);
        check({name, "_rom_clk_en"}, bus.rom_clk_en, 0);
        check({name, "_valid"}, bus.sccb_valid, 0);
        check({name, "_reg"}, bus.sccb_reg, 0);
        check({name, "_data"}, bus.sccb_data, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_error"}, error, 0);
    endtask

    task automatic clear_plan();
        for (int a = 0; a < 256; a++) rom[a] = 16'hFFFF;
        for (int i = 0; i < 1024; i++) nack_plan[i] = 1'b0;
    endtask

    task automatic run_seq(input string name);
        int budget = 0;
        model_run();
        reads       = 0;
        acc_cnt     = 0;
        wait_cycles = 0;
        fetched     = 1'b0;
        first_addr  = -1;
        last_acc    = ncyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({name, "_busy"}, busy, 1);
        while (busy && budget < 20000) begin
            start = inject_start && ($urandom_range(0, 63) == 0);
            tick();
            budget++;
        end
        start = 1'b0;
        check({name, "_idle"}, busy, 0);
        repeat (8) tick();
        check({name, "_writes"}, acc_cnt, exp_q.size());
        check({name, "_reads"}, reads, exp_reads);
        check({name, "_first_addr"}, first_addr, 0);
        check({name, "_last_addr"}, bus.rom_addr, exp_last_addr);
        check({name, "_done"}, done, exp_done);
        check({name, "_error"}, error, exp_error);
    endtask

    initial begin
        int budget;
        rst_n          = 1'b0;
        start          = 1'b0;
        ready_mode     = RDY_ALWAYS;
        hold_left      = 0;
        done_lat_min   = 3;
        done_lat_max   = 3;
        spurious_en    = 1'b0;
        inject_start   = 1'b0;
        reads          = 0;
        acc_cnt        = 0;
        wait_cycles    = 0;
        rom_pend       = 1'b0;
        bus.rom_dout   = '0;
        bus.sccb_ready = 1'b0;
        bus.sccb_done  = 1'b0;
        bus.sccb_nack  = 1'b0;
        clear_plan();
        repeat (3) tick();
        check_reset("por");
        rst_n = 1'b1;
        tick();

        // Write, settle delay, write, end marker.
        clear_plan();
        rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1201;
        run_seq("t1");

        // Back-pressure: ready low for the first 20 SEND cycles.
        clear_plan();
        rom[0] = 16'h1280;
        ready_mode = RDY_HOLD;
        hold_left  = 20;
        run_seq("t2");
        check("t2_wait_cycles", wait_cycles, 20);
        ready_mode = RDY_ALWAYS;

        // Two NACKs then an ACK on the same entry.
        clear_plan();
        rom[0] = 16'h1280; rom[1] = 16'h3A04;
        nack_plan[0] = 1'b1; nack_plan[1] = 1'b1;
        run_seq("t3");

        // Every attempt NACKed: abort with error, no further ROM reads.
        clear_plan();
        rom[0] = 16'h1280; rom[1] = 16'h1301;
        for (int i = 0; i < 4; i++) nack_plan[i] = 1'b1;
        run_seq("t4");

        // Full ROM with no end marker: stops at the last address.
        clear_plan();
        done_lat_min = 1;
        done_lat_max = 2;
        for (int a = 0; a < 256; a++) rom[a] = {1'b0, 15'($urandom)};
        run_seq("t5");

        // Reset during DELAY, then restart from address 0.
        clear_plan();
        rom[0] = 16'hFFF0; rom[1] = 16'h1234;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("t6a_busy_before", busy, 1);
        rst_n = 1'b0;
        tick();
        check_reset("t6a");
        rst_n = 1'b1;
        tick();
        run_seq("t6a_rerun");

        // Reset while a request is held in SEND.
        clear_plan();
        rom[0] = 16'h1280;
        ready_mode = RDY_HOLD;
        hold_left  = 1000;
        start = 1'b1;
        tick();
        start = 1'b0;
        budget = 0;
        while (!bus.sccb_valid && budget < 20) begin
            tick();
            budget++;
        end
        check("t6b_valid_before", bus.sccb_valid, 1);
        rst_n = 1'b0;
        tick();
        check_reset("t6b");
        rst_n = 1'b1;
        hold_left  = 0;
        ready_mode = RDY_ALWAYS;
        tick();
        run_seq("t6b_rerun");

        // Randomized ROMs, NACKs, back-pressure, stray done pulses and ignored restarts.
        ready_mode   = RDY_RANDOM;
        spurious_en  = 1'b1;
        inject_start = 1'b1;
        done_lat_min = 1;
        done_lat_max = 5;
        for (int run = 0; run < 6; run++) begin
            int len = int'($urandom_range(1, 300));
            for (int a = 0; a < 256; a++) begin
                if (a == len)                          rom[a] = 16'hFFFF;
                else if ($urandom_range(0, 15) == 0)   rom[a] = 16'hFFF0;
                else                                   rom[a] = 16'($urandom);
            end
            for (int i = 0; i < 1024; i++) nack_plan[i] = ($urandom_range(0, 3) == 0);
            run_seq($sformatf("rnd%0d", run));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
